mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single processor-memory port between the I-cache (loads only) and the D-cache (loads/stores).
//  Each cycle, forwards at most one command to memory and routes the acceptance response to the winner.
//  Later routes each returned data tag to the requester that owns that tag.
//  Sits between icache/dcache and the memory model; the caches see a private memory port each.
// PARAMETERS
//  TAG_W        4  width of memory response/tag; tag 0 = none, tags 1..2**TAG_W-1 valid
//  STARVE_LIMIT 4  consecutive I-cache denials after which I-cache gets priority for one grant
// PORTS
//  clock              in   1      system clock
//  reset              in   1      synchronous, active-high
//  Icache2arb_command in   2      BUS_NONE/BUS_LOAD (BUS_STORE from I-cache is treated as BUS_NONE)
//  Icache2arb_addr    in   XLEN   I-cache request address (8B aligned)
//  Dcache2arb_command in   2      BUS_NONE/BUS_LOAD/BUS_STORE
//  Dcache2arb_addr    in   XLEN   D-cache request address
//  Dcache2arb_data    in   64     store data
//  mem2arb_response   in   TAG_W  memory acceptance tag for this cycle's command (0 = rejected)
//  mem2arb_data       in   64     returned load data
//  mem2arb_tag        in   TAG_W  tag of returned data (0 = none)
//  arb2mem_command    out  2      forwarded command
//  arb2mem_addr       out  XLEN   forwarded address
//  arb2mem_data       out  64     forwarded store data (0 when I-cache wins)
//  arb2Icache_response out TAG_W  mem2arb_response if I-cache won, else 0
//  arb2Icache_data    out  64     mem2arb_data
//  arb2Icache_tag     out  TAG_W  mem2arb_tag if tag owned by I-cache, else 0
//  arb2Dcache_response out TAG_W  mem2arb_response if D-cache won, else 0
//  arb2Dcache_data    out  64     mem2arb_data
//  arb2Dcache_tag     out  TAG_W  mem2arb_tag if tag owned by D-cache, else 0
//  arb_error          out  1      sticky: data tag returned with no owner, or acceptance of an already-owned tag
// BEHAVIOUR
//  Grant (combinational, same cycle): D-cache wins when its command != BUS_NONE, unless starve_cnt==STARVE_LIMIT
//   and the I-cache is requesting; then the I-cache wins. With no requests, arb2mem_command=BUS_NONE and addr/data=0.
//  Loser sees response 0 that cycle and must hold/retry; the arbiter keeps no request queue.
//  starve_cnt (sequential): +1 (saturating at STARVE_LIMIT) when I-cache requests and loses or is rejected;
//   cleared when I-cache wins and response!=0; unchanged when I-cache is idle.
//  Owner table: per tag, valid + owner bits.
//   On winner LOAD with response!=0: set entry[response]={1,owner} at the clock edge.
//   A STORE does not allocate an entry (stores return no data tag).
//   On mem2arb_tag!=0 and entry valid: route tag to the owner and clear the entry at the clock edge.
//   Same tag freed and allocated in one cycle: allocation wins (entry ends valid with the new owner).
//   Tag returned with entry invalid: both caches see tag 0; set arb_error.
//   Allocation onto a valid entry: overwrite the entry; set arb_error.
//  Data outputs are broadcast unmasked; only the tag qualifies them.
//  Response/tag routing has zero latency (pure function of the current inputs and current table state).
//  Reset (sync): table cleared, starve_cnt=0, arb_error=0. While reset=1, arb2mem_command=BUS_NONE,
//   arb2mem_addr=0, arb2mem_data=0, and all response/tag outputs are 0.
//   Tags outstanding at reset are discarded; returning tags then raise arb_error only after reset deasserts.
// STRUCTURE
//  Shared package: ARB_OWNER enum {OWNER_I, OWNER_D}; TAG_OWNER_ENTRY struct {valid, owner}; BUS_COMMAND reused from sys_defs.
//  Sub-module mem_tag_owner_table: 2**TAG_W entries, alloc/free ports with the same-cycle rule above,
//   owner lookup by mem2arb_tag, error outputs.
//  Top: grant logic, starvation counter, output muxing, sticky error register.
// TESTING
//  1 Only I-cache LOAD 0x100, response=3; tag 3 next cycles -> arb2Icache_response=3, later arb2Icache_tag=3, D sees 0.
//  2 Both LOAD same cycle, resp=5 -> D-cache wins, arb2mem_addr=D addr, arb2Dcache_response=5, arb2Icache_response=0.
//  3 Both request for 5 cycles, all resp!=0 -> D wins cycles 0-3, I-cache wins cycle 4, starve_cnt back to 0.
//  4 D STORE resp=7, then tag 7 returned -> no D/I tag routed, arb_error=1.
//  5 I LOAD tag 2 outstanding; tag 2 returns while D LOAD accepted with resp=2 -> I sees tag 2; entry 2 now owned by D.
//  6 Allocate tags 1,4 then assert reset mid-flight -> outputs zero; after reset, tag 4 returned -> both tags 0, arb_error=1.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the processor-memory port arbiter and its tag owner table.
package mem_bus_arbiter_pkg;
  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } ARB_OWNER;

  typedef struct packed {
    logic     valid;
    ARB_OWNER owner;
  } TAG_OWNER_ENTRY;
endpackage

// File: rtl/mem_tag_owner_table.sv
// Per-tag owner record: allocated on accepted loads, released when the data tag returns.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  ARB_OWNER         alloc_owner,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output ARB_OWNER         hit_owner,
  output logic             err_orphan,
  output logic             err_realloc
);
  localparam int NUM_TAGS = 2 ** TAG_W;

  TAG_OWNER_ENTRY [NUM_TAGS-1:0] tbl_q, tbl_d;
  TAG_OWNER_ENTRY look_ent, alloc_ent;

  always_comb begin
    look_ent    = tbl_q[lookup_tag];
    alloc_ent   = tbl_q[alloc_tag];
    hit         = (lookup_tag != '0) && look_ent.valid;
    hit_owner   = look_ent.owner;
    err_orphan  = (lookup_tag != '0) && !look_ent.valid;
    // Reusing a tag that is being released this very cycle is legal.
    err_realloc = alloc_en && alloc_ent.valid && !(hit && (lookup_tag == alloc_tag));

    tbl_d = tbl_q;
    if (hit)      tbl_d[lookup_tag] = '0;
    if (alloc_en) tbl_d[alloc_tag]  = '{valid: 1'b1, owner: alloc_owner};
  end

  always_ff @(posedge clock) begin
    if (reset) tbl_q <= '0;
    else       tbl_q <= tbl_d;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between I-cache and D-cache: same-cycle grant with a
// starvation override for the I-cache, and tag-based routing of returned data.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       Icache2arb_command,
  input  logic [XLEN-1:0]  Icache2arb_addr,
  input  logic [1:0]       Dcache2arb_command,
  input  logic [XLEN-1:0]  Dcache2arb_addr,
  input  logic [63:0]      Dcache2arb_data,
  input  logic [TAG_W-1:0] mem2arb_response,
  input  logic [63:0]      mem2arb_data,
  input  logic [TAG_W-1:0] mem2arb_tag,
  output logic [1:0]       arb2mem_command,
  output logic [XLEN-1:0]  arb2mem_addr,
  output logic [63:0]      arb2mem_data,
  output logic [TAG_W-1:0] arb2Icache_response,
  output logic [63:0]      arb2Icache_data,
  output logic [TAG_W-1:0] arb2Icache_tag,
  output logic [TAG_W-1:0] arb2Dcache_response,
  output logic [63:0]      arb2Dcache_data,
  output logic [TAG_W-1:0] arb2Dcache_tag,
  output logic             arb_error
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
  logic            arb_error_q, arb_error_d;
  logic            i_req, d_req, i_win, d_win, accepted, alloc_en;
  logic            hit, err_orphan, err_realloc;
  ARB_OWNER        hit_owner, alloc_owner;

  always_comb begin
    i_req    = (Icache2arb_command == BUS_LOAD);
    d_req    = (Dcache2arb_command != BUS_NONE);
    i_win    = !reset && i_req && (!d_req || (starve_cnt_q == STARVE_MAX));
    d_win    = !reset && d_req && !i_win;
    accepted = (mem2arb_response != '0);

    arb2mem_command = BUS_NONE;
    arb2mem_addr    = '0;
    arb2mem_data    = '0;
    if (i_win) begin
      arb2mem_command = BUS_LOAD;
      arb2mem_addr    = Icache2arb_addr;
    end else if (d_win) begin
      arb2mem_command = Dcache2arb_command;
      arb2mem_addr    = Dcache2arb_addr;
      arb2mem_data    = Dcache2arb_data;
    end

    arb2Icache_response = i_win ? mem2arb_response : '0;
    arb2Dcache_response = d_win ? mem2arb_response : '0;
    arb2Icache_data     = mem2arb_data;
    arb2Dcache_data     = mem2arb_data;
    arb2Icache_tag      = (!reset && hit && hit_owner == OWNER_I) ? mem2arb_tag : '0;
    arb2Dcache_tag      = (!reset && hit && hit_owner == OWNER_D) ? mem2arb_tag : '0;

    // Stores return no data tag, so only accepted loads claim a table entry.
    alloc_en    = accepted && (i_win || (d_win && Dcache2arb_command == BUS_LOAD));
    alloc_owner = i_win ? OWNER_I : OWNER_D;

    starve_cnt_d = starve_cnt_q;
    if (i_req) begin
      if (i_win && accepted)              starve_cnt_d = '0;
      else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
    end

    arb_error_d = arb_error_q || (!reset && (err_orphan || err_realloc));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
      arb_error_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      arb_error_q  <= arb_error_d;
    end
  end

  assign arb_error = arb_error_q;

  mem_tag_owner_table #(.TAG_W(TAG_W)) u_owner_tbl (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2arb_response),
    .alloc_owner (alloc_owner),
    .lookup_tag  (mem2arb_tag),
    .hit         (hit),
    .hit_owner   (hit_owner),
    .err_orphan  (err_orphan),
    .err_realloc (err_realloc)
  );
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed checks of grant, starvation override, tag routing, errors and reset.
module tb_mem_bus_arbiter;
  localparam int TAG_W = 4;
  localparam int XLEN  = 64;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       Icache2arb_command, Dcache2arb_command;
  logic [XLEN-1:0]  Icache2arb_addr, Dcache2arb_addr;
  logic [63:0]      Dcache2arb_data, mem2arb_data;
  logic [TAG_W-1:0] mem2arb_response, mem2arb_tag;
  logic [1:0]       arb2mem_command;
  logic [XLEN-1:0]  arb2mem_addr;
  logic [63:0]      arb2mem_data, arb2Icache_data, arb2Dcache_data;
  logic [TAG_W-1:0] arb2Icache_response, arb2Icache_tag, arb2Dcache_response, arb2Dcache_tag;
  logic             arb_error;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bus_arbiter #(.TAG_W(TAG_W), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .Icache2arb_command(Icache2arb_command), .Icache2arb_addr(Icache2arb_addr),
    .Dcache2arb_command(Dcache2arb_command), .Dcache2arb_addr(Dcache2arb_addr),
    .Dcache2arb_data(Dcache2arb_data),
    .mem2arb_response(mem2arb_response), .mem2arb_data(mem2arb_data), .mem2arb_tag(mem2arb_tag),
    .arb2mem_command(arb2mem_command), .arb2mem_addr(arb2mem_addr), .arb2mem_data(arb2mem_data),
    .arb2Icache_response(arb2Icache_response), .arb2Icache_data(arb2Icache_data),
    .arb2Icache_tag(arb2Icache_tag),
    .arb2Dcache_response(arb2Dcache_response), .arb2Dcache_data(arb2Dcache_data),
    .arb2Dcache_tag(arb2Dcache_tag),
    .arb_error(arb_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Icache2arb_command = 2'd0; Icache2arb_addr = '0;
    Dcache2arb_command = 2'd0; Dcache2arb_addr = '0; Dcache2arb_data = '0;
    mem2arb_response = '0; mem2arb_data = '0; mem2arb_tag = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic step();
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    Dcache2arb_command = 2'd1; Dcache2arb_addr = 64'h300; mem2arb_response = 4'd3;
    #2;
    chk("rst_cmd",  64'(arb2mem_command), 64'd0);
    chk("rst_addr", arb2mem_addr, 64'd0);
    chk("rst_dresp", 64'(arb2Dcache_response), 64'd0);
    step();
    reset = 1'b0; idle();
    Dcache2arb_addr = 64'h777; Dcache2arb_data = 64'h55;
    #2;
    chk("rst_err", 64'(arb_error), 64'd0);
    chk("idle_cmd", 64'(arb2mem_command), 64'd0);
    chk("idle_addr", arb2mem_addr, 64'd0);
    chk("idle_data", arb2mem_data, 64'd0);

    // 1: I-cache alone
    step(); idle();
    Icache2arb_command = 2'd1; Icache2arb_addr = 64'h100; mem2arb_response = 4'd3;
    #2;
    chk("t1_cmd",   64'(arb2mem_command), 64'd1);
    chk("t1_addr",  arb2mem_addr, 64'h100);
    chk("t1_iresp", 64'(arb2Icache_response), 64'd3);
    chk("t1_dresp", 64'(arb2Dcache_response), 64'd0);
    step(); idle();
    mem2arb_tag = 4'd3; mem2arb_data = 64'hDEAD_BEEF_0000_0003;
    #2;
    chk("t1_itag",  64'(arb2Icache_tag), 64'd3);
    chk("t1_dtag",  64'(arb2Dcache_tag), 64'd0);
    chk("t1_idata", arb2Icache_data, 64'hDEAD_BEEF_0000_0003);
    chk("t1_ddata", arb2Dcache_data, 64'hDEAD_BEEF_0000_0003);

    // 2: both load, D wins
    step(); idle();
    Icache2arb_command = 2'd1; Icache2arb_addr = 64'h200;
    Dcache2arb_command = 2'd1; Dcache2arb_addr = 64'h300; mem2arb_response = 4'd5;
    #2;
    chk("t2_addr",  arb2mem_addr, 64'h300);
    chk("t2_dresp", 64'(arb2Dcache_response), 64'd5);
    chk("t2_iresp", 64'(arb2Icache_response), 64'd0);
    step(); idle();
    mem2arb_tag = 4'd5;
    #2;
    chk("t2_dtag", 64'(arb2Dcache_tag), 64'd5);
    chk("t2_itag", 64'(arb2Icache_tag), 64'd0);
    // solo I-cache grant clears the starvation count left by test 2
    step(); idle();
    Icache2arb_command = 2'd1; Icache2arb_addr = 64'h208; mem2arb_response = 4'd6;
    #2;
    chk("t2b_iresp", 64'(arb2Icache_response), 64'd6);
    step(); idle();
    mem2arb_tag = 4'd6;
    #2;
    chk("t2b_itag", 64'(arb2Icache_tag), 64'd6);

    // 3: starvation override on the fifth contested cycle
    for (int c = 0; c < 5; c++) begin
      step(); idle();
      Icache2arb_command = 2'd1; Icache2arb_addr = 64'h400;
      Dcache2arb_command = 2'd1; Dcache2arb_addr = 64'h500 + 64'(c * 8);
      Dcache2arb_data = 64'hABCD; mem2arb_response = 4'(c + 1);
      #2;
      if (c < 4) begin
        chk($sformatf("t3_dresp%0d", c), 64'(arb2Dcache_response), 64'(c + 1));
        chk($sformatf("t3_iresp%0d", c), 64'(arb2Icache_response), 64'd0);
      end else begin
        chk("t3_iresp4", 64'(arb2Icache_response), 64'd5);
        chk("t3_dresp4", 64'(arb2Dcache_response), 64'd0);
        chk("t3_addr4",  arb2mem_addr, 64'h400);
        chk("t3_data4",  arb2mem_data, 64'd0);
      end
    end
    step(); idle();
    Icache2arb_command = 2'd1; Icache2arb_addr = 64'h400;
    Dcache2arb_command = 2'd1; Dcache2arb_addr = 64'h600; mem2arb_response = 4'd6;
    #2;
    chk("t3_reset_cnt", 64'(arb2Dcache_response), 64'd6);
    for (int t = 1; t <= 6; t++) begin
      step(); idle();
      mem2arb_tag = 4'(t);
      #2;
      chk($sformatf("t3_itag%0d", t), 64'(arb2Icache_tag), (t == 5) ? 64'(t) : 64'd0);
      chk($sformatf("t3_dtag%0d", t), 64'(arb2Dcache_tag), (t == 5) ? 64'd0 : 64'(t));
    end

    // 5: free and reallocate tag 2 in the same cycle
    step(); idle();
    Icache2arb_command = 2'd1; Icache2arb_addr = 64'h700; mem2arb_response = 4'd2;
    step(); idle();
    Dcache2arb_command = 2'd1; Dcache2arb_addr = 64'h800; mem2arb_response = 4'd2;
    mem2arb_tag = 4'd2;
    #2;
    chk("t5_itag",  64'(arb2Icache_tag), 64'd2);
    chk("t5_dtag",  64'(arb2Dcache_tag), 64'd0);
    chk("t5_dresp", 64'(arb2Dcache_response), 64'd2);
    step(); idle();
    mem2arb_tag = 4'd2;
    #2;
    chk("t5_dtag2", 64'(arb2Dcache_tag), 64'd2);
    chk("t5_itag2", 64'(arb2Icache_tag), 64'd0);
    step(); idle();
    #2;
    chk("t5_err", 64'(arb_error), 64'd0);

    // 4: store allocates nothing; its tag coming back is an orphan
    Dcache2arb_command = 2'd2; Dcache2arb_addr = 64'h900;
    Dcache2arb_data = 64'h1234; mem2arb_response = 4'd7;
    #1;
    chk("t4_cmd",   64'(arb2mem_command), 64'd2);
    chk("t4_data",  arb2mem_data, 64'h1234);
    chk("t4_dresp", 64'(arb2Dcache_response), 64'd7);
    step(); idle();
    mem2arb_tag = 4'd7;
    #2;
    chk("t4_itag", 64'(arb2Icache_tag), 64'd0);
    chk("t4_dtag", 64'(arb2Dcache_tag), 64'd0);
    step(); idle();
    #2;
    chk("t4_err", 64'(arb_error), 64'd1);

    // 6: reset with tags outstanding
    step(); idle();
    Icache2arb_command = 2'd1; Icache2arb_addr = 64'hA00; mem2arb_response = 4'd1;
    step(); idle();
    Dcache2arb_command = 2'd1; Dcache2arb_addr = 64'hB00; mem2arb_response = 4'd4;
    step(); idle();
    reset = 1'b1;
    Dcache2arb_command = 2'd2; Dcache2arb_addr = 64'hC00; Dcache2arb_data = 64'h99;
    mem2arb_response = 4'd3; mem2arb_tag = 4'd1;
    #2;
    chk("t6_cmd",   64'(arb2mem_command), 64'd0);
    chk("t6_addr",  arb2mem_addr, 64'd0);
    chk("t6_data",  arb2mem_data, 64'd0);
    chk("t6_dresp", 64'(arb2Dcache_response), 64'd0);
    chk("t6_itag",  64'(arb2Icache_tag), 64'd0);
    step();
    #2;
    chk("t6_err_clr", 64'(arb_error), 64'd0);
    step();
    reset = 1'b0; idle();
    mem2arb_tag = 4'd4;
    #2;
    chk("t6_itag4", 64'(arb2Icache_tag), 64'd0);
    chk("t6_dtag4", 64'(arb2Dcache_tag), 64'd0);
    step(); idle();
    #2;
    chk("t6_err", 64'(arb_error), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
